// File: rtl/pipe_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_step_ctrl
// Purpose  : Step/run sequencer for the five-stage pipeline with LCD refresh
//            handshake; define PIPE_STEP_BP_EN to build breakpoint + HALT.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_step_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int RUN_DIV   = 4
) (
  input  logic        CCLK,
  input  logic        RSTN,
  input  logic        step_btn,
  input  logic        clr_btn,
  input  logic        run_sw,
  input  logic [31:0] if_pc,
  input  logic [31:0] bp_pc,
  input  logic        lcd_ack,
  output logic        pipe_ce,
  output logic        pipe_clr,
  output logic        lcd_req,
  output logic [7:0]  clk_cnt,
  output logic        halted
);

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int DVW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_ADV  = 3'd1;
  localparam logic [2:0] c_ST_SYNC = 3'd2;
  localparam logic [2:0] c_ST_RUN  = 3'd3;
  localparam logic [2:0] c_ST_HALT = 3'd4;

  logic [1:0]     w_btn_raw;
  logic [1:0]     w_btn_ev;
  logic           w_step_ev;
  logic           w_clr_ev;
  logic           run_s1_q;
  logic           run_s2_q;
  logic [2:0]     state_q, state_d;
  logic [7:0]     clk_cnt_q, clk_cnt_d;
  logic [DVW-1:0] div_q, div_d;
  logic           w_bp_match;
  logic           w_bp_hit;

  assign w_btn_raw = {clr_btn, step_btn};
  assign w_step_ev = w_btn_ev[0];
  assign w_clr_ev  = w_btn_ev[1];

  // Index 0 = step, index 1 = clear; each yields a one-cycle rising-edge event.
  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    logic           sync1_q;
    logic           sync2_q;
    logic           level_q;
    logic           level_dly_q;
    logic           ev_q;
    logic [DBW-1:0] cnt_q;

    always_ff @(posedge CCLK or negedge RSTN) begin
      if (!RSTN) begin
        sync1_q     <= 1'b0;
        sync2_q     <= 1'b0;
        level_q     <= 1'b0;
        level_dly_q <= 1'b0;
        ev_q        <= 1'b0;
        cnt_q       <= '0;
      end else begin
        sync1_q     <= w_btn_raw[gi];
        sync2_q     <= sync1_q;
        level_dly_q <= level_q;
        ev_q        <= level_q & ~level_dly_q;
        if (sync2_q != level_q) begin
          if (cnt_q == DBW'(DB_CYCLES - 1)) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign w_btn_ev[gi] = ev_q;
  end

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
    end else begin
      run_s1_q <= run_sw;
      run_s2_q <= run_s1_q;
    end
  end

`ifdef PIPE_STEP_BP_EN
  logic bp_hit_q, bp_hit_d;

  // The PC is checked in the cycle after each run-mode advance.
  assign w_bp_match = (state_q == c_ST_RUN) && (div_q == DVW'(1)) && (if_pc == bp_pc);
  assign w_bp_hit   = bp_hit_q;

  always_comb begin
    bp_hit_d = bp_hit_q;
    if (w_clr_ev) begin
      bp_hit_d = 1'b0;
    end else if (w_bp_match) begin
      bp_hit_d = 1'b1;
    end else if ((state_q == c_ST_SYNC) && lcd_ack) begin
      bp_hit_d = 1'b0;
    end
  end

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^{if_pc, bp_pc};
  assign w_bp_match  = 1'b0;
  assign w_bp_hit    = 1'b0;
`endif

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_clr_ev) begin
      state_d = c_ST_IDLE;
    end else begin
      case (state_q)
        c_ST_IDLE: begin
          if (w_step_ev) begin
            state_d = c_ST_ADV;
          end else if (run_s2_q) begin
            state_d = c_ST_RUN;
          end
        end
        c_ST_ADV:  state_d = c_ST_SYNC;
        c_ST_SYNC: begin
          if (lcd_ack) begin
            if (w_bp_hit) begin
              state_d = c_ST_HALT;
            end else if (run_s2_q) begin
              state_d = c_ST_RUN;
            end else begin
              state_d = c_ST_IDLE;
            end
          end
        end
        c_ST_RUN: begin
          if (w_bp_match || !run_s2_q) begin
            state_d = c_ST_SYNC;
          end
        end
        c_ST_HALT: begin
          if (w_step_ev) begin
            state_d = c_ST_ADV;
          end
        end
        default:   state_d = c_ST_IDLE;
      endcase
    end
  end

  // A clear event masks advance and refresh so pipe_ce never meets pipe_clr.
  always_comb begin
    pipe_ce  = 1'b0;
    lcd_req  = 1'b0;
    pipe_clr = w_clr_ev;
    halted   = (state_q == c_ST_HALT);
    if (!w_clr_ev) begin
      case (state_q)
        c_ST_ADV:  pipe_ce = 1'b1;
        c_ST_RUN:  pipe_ce = (div_q == '0);
        c_ST_SYNC: lcd_req = 1'b1;
        default:   pipe_ce = 1'b0;
      endcase
    end
  end

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    div_d     = '0;
    if (w_clr_ev) begin
      clk_cnt_d = 8'd0;
    end else begin
      if (pipe_ce) begin
        clk_cnt_d = clk_cnt_q + 8'd1;
      end
      if ((state_q == c_ST_RUN) && (div_q != DVW'(RUN_DIV - 1))) begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      clk_cnt_q <= 8'd0;
      div_q     <= '0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      div_q     <= div_d;
    end
  end

  assign clk_cnt = clk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_step_ctrl
// Purpose  : Scoreboard bench for pipe_step_ctrl (DB_CYCLES=4, RUN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_step_ctrl;
  localparam int DB = 4;
  localparam int RD = 4;

  localparam int P_CE   = 0;
  localparam int P_CLR  = 1;
  localparam int P_REQ  = 2;
  localparam int P_CNT  = 3;
  localparam int P_HALT = 4;

  logic        CCLK     = 1'b0;
  logic        RSTN     = 1'b0;
  logic        step_btn = 1'b0;
  logic        clr_btn  = 1'b0;
  logic        run_sw   = 1'b0;
  logic        ack_man  = 1'b0;
  logic        ack_auto = 1'b0;
  logic        pc_en    = 1'b0;
  logic [31:0] if_pc    = 32'd0;
  logic [31:0] bp_pc    = 32'hFFFF_FFF0;
  wire         lcd_ack;
  logic        pipe_ce, pipe_clr, lcd_req, halted;
  logic [7:0]  clk_cnt;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;

  typedef struct { logic clr; logic [7:0] cnt; int cyc; } pulse_t;
  typedef struct { int cyc; int sel; logic [7:0] val; } probe_t;
  pulse_t pq[$];
  probe_t prq[$];

  assign lcd_ack = ack_auto ? lcd_req : ack_man;

  pipe_step_ctrl #(.DB_CYCLES(DB), .RUN_DIV(RD)) dut (
    .CCLK    (CCLK),
    .RSTN    (RSTN),
    .step_btn(step_btn),
    .clr_btn (clr_btn),
    .run_sw  (run_sw),
    .if_pc   (if_pc),
    .bp_pc   (bp_pc),
    .lcd_ack (lcd_ack),
    .pipe_ce (pipe_ce),
    .pipe_clr(pipe_clr),
    .lcd_req (lcd_req),
    .clk_cnt (clk_cnt),
    .halted  (halted)
  );

  always #5 CCLK = ~CCLK;
  always @(posedge CCLK) cyc <= cyc + 1;

  // Fetch-stage stand-in: PC advances by one word per pipeline advance.
  always @(posedge CCLK) if (pc_en && pipe_ce) if_pc <= if_pc + 32'd4;

  function automatic string sel_name(input int s);
    case (s)
      P_CE:    return "pipe_ce";
      P_CLR:   return "pipe_clr";
      P_REQ:   return "lcd_req";
      P_CNT:   return "clk_cnt";
      default: return "halted";
    endcase
  endfunction

  function automatic logic [7:0] sel_val(input int s);
    case (s)
      P_CE:    return {7'd0, pipe_ce};
      P_CLR:   return {7'd0, pipe_clr};
      P_REQ:   return {7'd0, lcd_req};
      P_CNT:   return clk_cnt;
      default: return {7'd0, halted};
    endcase
  endfunction

  always @(negedge CCLK) begin : mon
    pulse_t     e;
    probe_t     p;
    logic [7:0] act;
    if (pipe_ce || pipe_clr) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got ce=%0b clr=%0b cnt=%0d at cycle %0d, required no pulse",
                 pipe_ce, pipe_clr, clk_cnt, cyc);
      end else begin
        e = pq.pop_front();
        if (pipe_clr !== e.clr || pipe_ce !== !e.clr || clk_cnt !== e.cnt || cyc != e.cyc) begin
          errors++;
          $display("FAIL pulse_%s: got ce=%0b clr=%0b cnt=%0d cycle=%0d, required clr=%0b cnt=%0d cycle=%0d",
                   e.clr ? "clr" : "ce", pipe_ce, pipe_clr, clk_cnt, cyc, e.clr, e.cnt, e.cyc);
        end
      end
    end
    while (prq.size() != 0 && prq[0].cyc <= cyc) begin
      p   = prq.pop_front();
      act = sel_val(p.sel);
      checks++;
      if (p.cyc != cyc || act !== p.val) begin
        errors++;
        $display("FAIL probe_%s@%0d: got %0d (at cycle %0d), required %0d",
                 sel_name(p.sel), p.cyc, act, cyc, p.val);
      end
    end
    if (done) begin
      checks++;
      if (pq.size() != 0 || prq.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain: got %0d pulses and %0d probes outstanding, required 0",
                 pq.size(), prq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic to_cyc(input int n);
    int k;
    k = n - cyc;
    repeat (k) @(posedge CCLK);
    #1;
  endtask

  task automatic exp_pulse(input logic clr, input logic [7:0] cnt, input int c);
    pq.push_back('{clr, cnt, c});
  endtask

  task automatic probe(input int c, input int sel, input logic [7:0] v);
    prq.push_back('{c, sel, v});
  endtask

  initial begin
    int c;
    int p_end;
    logic [7:0] cnt_base;

    // Reset state
    for (int s = 0; s <= P_HALT; s++) probe(1, s, 8'd0);
    to_cyc(2);
    RSTN = 1'b1;

    // Bouncing step button never settles long enough
    c = cyc + 2;
    for (int i = 0; i < 15; i++) begin
      to_cyc(c + 2 * i);
      step_btn = (i % 2 == 0);
    end
    to_cyc(c + 30);
    step_btn = 1'b0;
    probe(c + 45, P_CNT, 8'd0);
    to_cyc(c + 46);

    // Single step: ce 7 cycles after first sample, refresh held until ack
    c = cyc + 2;
    to_cyc(c);
    step_btn = 1'b1;
    exp_pulse(1'b0, 8'd0, c + 8);
    probe(c + 9,  P_REQ,  8'd1);
    probe(c + 9,  P_CNT,  8'd1);
    probe(c + 12, P_REQ,  8'd1);
    probe(c + 13, P_REQ,  8'd0);
    probe(c + 13, P_HALT, 8'd0);
    to_cyc(c + 12);
    ack_man = 1'b1;
    to_cyc(c + 13);
    ack_man = 1'b0;
    to_cyc(c + 20);
    step_btn = 1'b0;
    probe(c + 40, P_CNT, 8'd1);
    to_cyc(c + 41);

    // Step and clear together: clear wins
    c = cyc + 2;
    to_cyc(c);
    step_btn = 1'b1;
    clr_btn  = 1'b1;
    exp_pulse(1'b1, 8'd1, c + 7);
    probe(c + 7, P_CE,  8'd0);
    probe(c + 8, P_CE,  8'd0);
    probe(c + 8, P_CNT, 8'd0);
    probe(c + 9, P_REQ, 8'd0);
    to_cyc(c + 12);
    step_btn = 1'b0;
    clr_btn  = 1'b0;
    to_cyc(c + 30);

    // Clear pressed while waiting in SYNC
    c = cyc + 2;
    to_cyc(c);
    step_btn = 1'b1;
    exp_pulse(1'b0, 8'd0, c + 8);
    to_cyc(c + 9);
    clr_btn = 1'b1;
    exp_pulse(1'b1, 8'd1, c + 16);
    probe(c + 15, P_REQ, 8'd1);
    probe(c + 16, P_REQ, 8'd0);
    probe(c + 17, P_REQ, 8'd0);
    probe(c + 17, P_CNT, 8'd0);
    to_cyc(c + 22);
    step_btn = 1'b0;
    clr_btn  = 1'b0;
    to_cyc(c + 40);

    // Free run, 258 advances, counter wraps past 255
    ack_auto = 1'b1;
    c = cyc + 2;
    to_cyc(c);
    run_sw = 1'b1;
    for (int i = 0; i < 258; i++) exp_pulse(1'b0, 8'(i), c + 3 + 4 * i);
    probe(c + 3 + 4 * 255 + 1, P_CNT, 8'd0);
    p_end = c + 3 + 4 * 257;
    probe(p_end + 3, P_REQ, 8'd1);
    probe(p_end + 4, P_REQ, 8'd0);
    probe(p_end + 5, P_CNT, 8'd2);
    to_cyc(p_end);
    run_sw = 1'b0;
    to_cyc(p_end + 10);
    ack_auto = 1'b0;

    // Clear back to zero
    c = cyc + 2;
    to_cyc(c);
    clr_btn = 1'b1;
    exp_pulse(1'b1, 8'd2, c + 7);
    probe(c + 8, P_CNT, 8'd0);
    to_cyc(c + 10);
    clr_btn = 1'b0;
    to_cyc(c + 25);

    // Breakpoint at PC 0xC during free run
    bp_pc = 32'h0000_000C;
    pc_en = 1'b1;
    c = cyc + 2;
    to_cyc(c);
    run_sw = 1'b1;
`ifdef PIPE_STEP_BP_EN
    exp_pulse(1'b0, 8'd0, c + 3);
    exp_pulse(1'b0, 8'd1, c + 7);
    exp_pulse(1'b0, 8'd2, c + 11);
    probe(c + 13, P_REQ,  8'd1);
    probe(c + 15, P_REQ,  8'd1);
    probe(c + 15, P_HALT, 8'd0);
    probe(c + 16, P_HALT, 8'd1);
    probe(c + 16, P_REQ,  8'd0);
    probe(c + 16, P_CNT,  8'd3);
    to_cyc(c + 15);
    ack_man = 1'b1;
    to_cyc(c + 16);
    ack_man = 1'b0;
    run_sw  = 1'b0;
    probe(c + 25, P_HALT, 8'd1);
    to_cyc(c + 26);
    step_btn = 1'b1;
    exp_pulse(1'b0, 8'd3, c + 34);
    probe(c + 33, P_HALT, 8'd1);
    probe(c + 34, P_HALT, 8'd0);
    probe(c + 37, P_HALT, 8'd0);
    probe(c + 37, P_REQ,  8'd0);
    probe(c + 37, P_CNT,  8'd4);
    to_cyc(c + 36);
    ack_man = 1'b1;
    to_cyc(c + 37);
    ack_man = 1'b0;
    to_cyc(c + 40);
    step_btn = 1'b0;
    to_cyc(c + 60);
    cnt_base = 8'd4;
`else
    ack_auto = 1'b1;
    for (int i = 0; i < 6; i++) exp_pulse(1'b0, 8'(i), c + 3 + 4 * i);
    p_end = c + 23;
    probe(c + 16, P_HALT, 8'd0);
    probe(p_end + 3, P_REQ,  8'd1);
    probe(p_end + 5, P_CNT,  8'd6);
    probe(p_end + 5, P_HALT, 8'd0);
    to_cyc(p_end);
    run_sw = 1'b0;
    to_cyc(p_end + 10);
    ack_auto = 1'b0;
    cnt_base = 8'd6;
`endif
    pc_en = 1'b0;
    bp_pc = 32'hFFFF_FFF0;

    // Asynchronous reset between divider ticks, run resumes from zero
    ack_auto = 1'b1;
    c = cyc + 2;
    to_cyc(c);
    run_sw = 1'b1;
    exp_pulse(1'b0, cnt_base, c + 3);
    exp_pulse(1'b0, cnt_base + 8'd1, c + 7);
    for (int s = 0; s <= P_HALT; s++) probe(c + 8, s, 8'd0);
    to_cyc(c + 8);
    #1;
    RSTN = 1'b0;
    to_cyc(c + 10);
    RSTN = 1'b1;
    exp_pulse(1'b0, 8'd0, c + 13);
    exp_pulse(1'b0, 8'd1, c + 17);
    probe(c + 18, P_CNT, 8'd2);
    probe(c + 20, P_REQ, 8'd1);
    probe(c + 21, P_REQ, 8'd0);
    probe(c + 22, P_CNT, 8'd2);
    to_cyc(c + 17);
    run_sw = 1'b0;
    to_cyc(c + 25);
    ack_auto = 1'b0;
    done = 1'b1;
  end

endmodule
`default_nettype wire
